// File: rtl/nios_led_pkg.sv
// Shared state and mode encodings for the Nios LED driver.
package nios_led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ON,
        ST_BLINK_ON,
        ST_BLINK_OFF,
        ST_HOLD
    } led_state_e;

    localparam logic [1:0] MODE_FOLLOW  = 2'b00;
    localparam logic [1:0] MODE_BLINK   = 2'b01;
    localparam logic [1:0] MODE_STRETCH = 2'b10;
    localparam logic [1:0] MODE_OFF     = 2'b11;

endpackage

// File: rtl/nios_led_tick_gen.sv
// Prescaler producing a one-cycle tick every PRESCALE_DIV clocks.
// A synchronous clear restarts the period from zero.
module nios_led_tick_gen #(
    parameter int unsigned PRESCALE_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned CNT_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nios_led_driver.sv
// LED pin driver behind the Nios LED PIO: steady follow, blink while
// requested, or pulse-stretch on a request rising edge.
module nios_led_driver
    import nios_led_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV     = 50000,
    parameter int unsigned BLINK_HALF_TICKS = 250,
    parameter int unsigned STRETCH_TICKS    = 100,
    parameter bit          ACTIVE_LOW       = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       led_req,
    input  logic [1:0] led_mode,
    output logic       led_pin,
    output logic       busy
);

    localparam int unsigned MAX_TICKS = (BLINK_HALF_TICKS > STRETCH_TICKS) ?
                                        BLINK_HALF_TICKS : STRETCH_TICKS;
    localparam int unsigned TCNT_W    = $clog2(MAX_TICKS + 1);
    localparam logic [TCNT_W-1:0] BLINK_TERM   = TCNT_W'(BLINK_HALF_TICKS - 1);
    localparam logic [TCNT_W-1:0] STRETCH_TERM = TCNT_W'(STRETCH_TICKS - 1);

    led_state_e        state;
    led_state_e        state_n;
    logic [1:0]        mode_q;
    logic              req_d;
    logic [TCNT_W-1:0] tick_cnt;
    logic              tick_c;
    logic              rise_c;
    logic              mode_chg_c;
    logic              timed_c;
    logic              restart_c;
    logic              clr_c;
    logic              term_blink_c;
    logic              term_stretch_c;
    logic              lit_n_c;

    assign rise_c         = led_req & ~req_d;
    assign mode_chg_c     = (led_mode != mode_q);
    assign timed_c        = (state == ST_BLINK_ON) || (state == ST_BLINK_OFF) ||
                            (state == ST_HOLD);
    assign term_blink_c   = tick_c && (tick_cnt == BLINK_TERM);
    assign term_stretch_c = tick_c && (tick_cnt == STRETCH_TERM);
    // Counters stay parked at zero outside timed states and restart on every entry.
    assign clr_c          = mode_chg_c || restart_c || (state_n != state) || !timed_c;
    assign lit_n_c        = (state_n == ST_ON) || (state_n == ST_BLINK_ON) ||
                            (state_n == ST_HOLD);

    nios_led_tick_gen #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (clr_c),
        .tick_c(tick_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_FOLLOW;
            req_d    <= 1'b1;
            tick_cnt <= '0;
            led_pin  <= ACTIVE_LOW;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            mode_q   <= led_mode;
            req_d    <= led_req;
            led_pin  <= lit_n_c ^ ACTIVE_LOW;
            busy     <= (state_n != ST_IDLE);
            if (clr_c) begin
                tick_cnt <= '0;
            end else if (tick_c) begin
                tick_cnt <= tick_cnt + TCNT_W'(1);
            end
        end
    end

    // Next-state: a mode change wins over everything, then per-mode rules.
    always_comb begin
        state_n   = state;
        restart_c = 1'b0;
        if (mode_chg_c) begin
            state_n = ST_IDLE;
        end else begin
            case (led_mode)
                MODE_FOLLOW: begin
                    state_n = led_req ? ST_ON : ST_IDLE;
                end
                MODE_BLINK: begin
                    if (!led_req) begin
                        state_n = ST_IDLE;
                    end else begin
                        case (state)
                            ST_IDLE:      state_n = ST_BLINK_ON;
                            ST_BLINK_ON:  if (term_blink_c) state_n = ST_BLINK_OFF;
                            ST_BLINK_OFF: if (term_blink_c) state_n = ST_BLINK_ON;
                            default:      state_n = ST_IDLE;
                        endcase
                    end
                end
                MODE_STRETCH: begin
                    if (rise_c) begin
                        state_n   = ST_HOLD;
                        restart_c = 1'b1;
                    end else if (state == ST_HOLD) begin
                        if (term_stretch_c) state_n = ST_IDLE;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_led_driver.sv
// Directed self-checking bench for nios_led_driver with a small prescale
// so timed behaviour resolves in tens of cycles.
module tb_nios_led_driver;

    logic       clk;
    logic       reset;
    logic       led_req;
    logic [1:0] led_mode;
    logic       led_pin;
    logic       busy;

    int checks;
    int errors;

    nios_led_driver #(
        .PRESCALE_DIV    (4),
        .BLINK_HALF_TICKS(3),
        .STRETCH_TICKS   (5),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .led_req (led_req),
        .led_mode(led_mode),
        .led_pin (led_pin),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        led_req  = 1'b1;
        led_mode = 2'b10;
        step();
        step();
        checks++;
        if (led_pin !== 1'b1) begin
            errors++;
            $display("FAIL reset_pin got %b expected 1", led_pin);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b expected 0", busy);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (led_pin !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_stretch cyc %0d got pin=%b busy=%b expected pin=1 busy=0",
                         i, led_pin, busy);
            end
        end
    endtask

    task automatic test_follow();
        led_mode = 2'b00;
        led_req  = 1'b0;
        step();
        step();
        led_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (led_pin !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL follow_on cyc %0d got pin=%b busy=%b expected pin=0 busy=1",
                         i, led_pin, busy);
            end
        end
        led_req = 1'b0;
        step();
        checks++;
        if (led_pin !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL follow_off got pin=%b busy=%b expected pin=1 busy=0", led_pin, busy);
        end
    endtask

    task automatic test_blink();
        logic exp_pin;
        led_mode = 2'b01;
        led_req  = 1'b0;
        step();
        step();
        led_req = 1'b1;
        for (int i = 0; i < 53; i++) begin
            step();
            exp_pin = ((i / 12) % 2) != 0;
            checks++;
            if (led_pin !== exp_pin || busy !== 1'b1) begin
                errors++;
                $display("FAIL blink cyc %0d got pin=%b busy=%b expected pin=%b busy=1",
                         i, led_pin, busy, exp_pin);
            end
        end
        led_req = 1'b0;
        step();
        checks++;
        if (led_pin !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL blink_drop got pin=%b busy=%b expected pin=1 busy=0", led_pin, busy);
        end
    endtask

    task automatic test_stretch();
        logic exp_pin;
        led_mode = 2'b10;
        led_req  = 1'b0;
        step();
        step();
        for (int i = 0; i < 22; i++) begin
            led_req = (i == 0);
            step();
            exp_pin = (i < 20) ? 1'b0 : 1'b1;
            checks++;
            if (led_pin !== exp_pin || busy !== ~exp_pin) begin
                errors++;
                $display("FAIL stretch_single cyc %0d got pin=%b busy=%b expected pin=%b busy=%b",
                         i, led_pin, busy, exp_pin, ~exp_pin);
            end
        end
        for (int i = 0; i < 32; i++) begin
            led_req = (i == 0) || (i == 10);
            step();
            exp_pin = (i < 30) ? 1'b0 : 1'b1;
            checks++;
            if (led_pin !== exp_pin || busy !== ~exp_pin) begin
                errors++;
                $display("FAIL stretch_retrigger cyc %0d got pin=%b busy=%b expected pin=%b busy=%b",
                         i, led_pin, busy, exp_pin, ~exp_pin);
            end
        end
        led_req = 1'b0;
    endtask

    task automatic test_mode_change();
        led_mode = 2'b01;
        led_req  = 1'b1;
        step();
        step();
        step();
        step();
        step();
        checks++;
        if (led_pin !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mode_pre got pin=%b busy=%b expected pin=0 busy=1", led_pin, busy);
        end
        led_mode = 2'b11;
        step();
        checks++;
        if (led_pin !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mode_off got pin=%b busy=%b expected pin=1 busy=0", led_pin, busy);
        end
        checks++;
        if (dut.tick_cnt !== '0 || dut.u_tick.cnt !== '0) begin
            errors++;
            $display("FAIL mode_counters got tick_cnt=%0d presc=%0d expected 0 0",
                     dut.tick_cnt, dut.u_tick.cnt);
        end
        step();
        step();
        checks++;
        if (led_pin !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mode_off_hold got pin=%b busy=%b expected pin=1 busy=0", led_pin, busy);
        end
    endtask

    task automatic test_reset_mid_hold();
        led_mode = 2'b10;
        led_req  = 1'b0;
        step();
        step();
        led_req = 1'b1;
        step();
        led_req = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (led_pin !== 1'b0) begin
            errors++;
            $display("FAIL hold_pre_reset got pin=%b expected 0", led_pin);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (led_pin !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got pin=%b busy=%b expected pin=1 busy=0", led_pin, busy);
        end
        led_req = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (led_pin !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_dark cyc %0d got pin=%b busy=%b expected pin=1 busy=0",
                         i, led_pin, busy);
            end
        end
        led_req = 1'b0;
        step();
        led_req = 1'b1;
        step();
        checks++;
        if (led_pin !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_relight got pin=%b busy=%b expected pin=0 busy=1",
                     led_pin, busy);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        led_req  = 1'b1;
        led_mode = 2'b10;
        test_reset();
        test_follow();
        test_blink();
        test_stretch();
        test_mode_change();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
